filter_feeder: RTL

Input conditioning stage placed directly upstream of the interpolating switchable FIR filter. It accepts bursty 8-bit samples over a valid/ready handshake, buffers them in a small FIFO and presents one sample per filter sampling period on the filter's `in`. It also drives the filter's `switch` so that rate changes land only on period boundaries. An underrun is reported whenever the FIFO has no sample ready at a sampling edge.

---
 rtl/filter_feeder_if.sv | 9 +
 rtl/filter_feeder.sv | 95 +++++++++
 2 files changed

// File: rtl/filter_feeder_if.sv
// Producer-side valid/ready sample bus feeding filter_feeder.
interface filter_feeder_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/filter_feeder.sv
// Buffers bursty samples and presents one per filter sampling period; drives filter switch.
// Build option FILTER_FEEDER_ZERO_FILL_EN: underrun inserts 0 instead of repeating the last sample.
module filter_feeder #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   Clock,
  input  logic                   reset,
  filter_feeder_if.slave         up,
  input  logic                   rate_req,
  output logic [7:0]             in_data,
  output logic                   switch,
  output logic                   sample_tick,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             underrun_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [1:0]    ph;
  logic          per_long;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];

  logic push;
  logic pop;
  logic underrun;
  logic ph_last;

  assign sample_tick = (ph == 2'd0);
  assign up.s_ready  = (level != LW'(DEPTH));
  assign push        = up.s_valid && up.s_ready;
  assign pop         = sample_tick && (level != '0);
  assign underrun    = sample_tick && (level == '0);
  // per_long holds the switch value the filter evaluated at the last sampling edge
  assign ph_last     = per_long ? (ph == 2'd3) : (ph == 2'd1);

  // Phase counter and rate switch
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      ph       <= 2'd0;
      switch   <= 1'b0;
      per_long <= 1'b0;
    end else if (sample_tick) begin
      ph       <= 2'd1;
      switch   <= rate_req;
      per_long <= switch;
    end else if (ph_last) begin
      ph <= 2'd0;
    end else begin
      ph <= ph + 2'd1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sample storage
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= up.s_data;
  end

  // Filter input register and underrun counter
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      in_data      <= 8'h00;
      underrun_cnt <= 8'h00;
    end else if (pop) begin
      in_data <= mem[rd_ptr];
    end else if (underrun) begin
`ifdef FILTER_FEEDER_ZERO_FILL_EN
      in_data <= 8'h00;
`else
      in_data <= in_data;
`endif
      if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule
